// File: rtl/ahblite_keypad_scanner.sv
// AHB-Lite keypad scanner: walks an active-low row strobe across a key matrix, debounces
// each key and queues press/release events in a FIFO with a level interrupt.
module ahblite_keypad_scanner #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    output logic [ROWS-1:0]  Row,
    input  logic [COLS-1:0]  Col,
    output logic             IRQ
);
    localparam int unsigned NKEY  = ROWS * COLS;
    localparam int unsigned CUR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EVT_W = 9;

    logic               r_dp_valid, r_dp_write;
    logic [1:0]         r_dp_addr;
    logic [1:0]         r_ctrl;
    logic               r_ovf, r_irq;
    logic [COLS-1:0]    r_col_s1, r_col_s2;
    logic [DIV_W-1:0]   r_div;
    logic [CUR_W-1:0]   r_cur, r_pend_row;
    logic [COLS-1:0]    r_pend, r_pend_press;
    logic [NKEY-1:0]    r_stable;
    logic [3:0]         r_dbcnt [NKEY];
    logic [EVT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_wr_ctrl, w_wr_stat, w_rd_event, w_tick;
    logic [COLS-1:0]    w_sample, w_flip, w_pend_sel;
    logic [3:0]         w_push_col;
    logic               w_push_press, w_push, w_push_ok, w_pop, w_empty, w_full;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_ovf_nxt;
    logic [1:0]         w_ctrl_nxt;
    logic               w_unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = r_irq;
    assign Row       = r_ctrl[0] ? ~(ROWS'(1) << r_cur) : '1;
    assign w_unused  = ^{HADDR[31:4], HADDR[1:0], HSIZE, HPROT, HWDATA[31:3]};

    // Address phase capture; the access acts in the following cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
        end else begin
            r_dp_valid <= HSEL & HTRANS[1] & HREADY;
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[3:2];
        end
    end

    assign w_wr_ctrl  = r_dp_valid &  r_dp_write & (r_dp_addr == 2'd0);
    assign w_wr_stat  = r_dp_valid &  r_dp_write & (r_dp_addr == 2'd1);
    assign w_rd_event = r_dp_valid & ~r_dp_write & (r_dp_addr == 2'd2);
    assign w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_sample   = ~r_col_s2;

    // Keys of the current row whose debounce count is about to expire.
    always_comb begin
        w_flip = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((CUR_W'(r) == r_cur) && (w_sample[c] != r_stable[r*COLS+c]) &&
                    (r_dbcnt[r*COLS+c] == 4'(DEBOUNCE - 1)))
                    w_flip[c] = 1'b1;
            end
        end
    end

    // Lowest pending column goes out first.
    always_comb begin
        w_push_col   = 4'd0;
        w_push_press = 1'b0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (r_pend[c]) begin
                w_push_col   = 4'(c);
                w_push_press = r_pend_press[c];
            end
        end
        w_push     = r_ctrl[0] & (|r_pend);
        w_pend_sel = w_push ? (COLS'(1) << w_push_col) : '0;
    end

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop       = w_rd_event & ~w_empty;
        w_push_ok   = w_push & (~w_full | w_pop);
        w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
        w_ovf_nxt   = (w_push & ~w_push_ok) | (r_ovf & ~(w_wr_stat & HWDATA[2]));
        w_ctrl_nxt  = w_wr_ctrl ? HWDATA[1:0] : r_ctrl;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= Col;
            r_col_s2 <= r_col_s1;
        end
    end

    // Scan engine; clearing EN wipes all scan state but leaves the FIFO alone.
    always_ff @(posedge HCLK) begin
        if (HRESET || !r_ctrl[0]) begin
            r_div        <= '0;
            r_cur        <= '0;
            r_pend_row   <= '0;
            r_pend       <= '0;
            r_pend_press <= '0;
            r_stable     <= '0;
            for (int k = 0; k < NKEY; k++) r_dbcnt[k] <= 4'd0;
        end else begin
            r_pend <= (r_pend & ~w_pend_sel) | (w_tick ? w_flip : '0);
            if (w_tick) begin
                r_div        <= '0;
                r_cur        <= (r_cur == CUR_W'(ROWS - 1)) ? '0 : r_cur + CUR_W'(1);
                r_pend_row   <= r_cur;
                r_pend_press <= w_sample;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (CUR_W'(r) == r_cur) begin
                            if (w_sample[c] == r_stable[r*COLS+c]) begin
                                r_dbcnt[r*COLS+c] <= 4'd0;
                            end else if (w_flip[c]) begin
                                r_stable[r*COLS+c] <= w_sample[c];
                                r_dbcnt[r*COLS+c]  <= 4'd0;
                            end else begin
                                r_dbcnt[r*COLS+c] <= r_dbcnt[r*COLS+c] + 4'd1;
                            end
                        end
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {w_push_press, 4'(r_pend_row), w_push_col};
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ctrl   <= 2'd0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_ctrl  <= w_ctrl_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= w_count_nxt;
            r_irq   <= w_ctrl_nxt[1] & ((w_count_nxt != '0) | w_ovf_nxt);
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        case (r_dp_addr)
            2'd0: HRDATA = {30'd0, r_ctrl};
            2'd1: HRDATA = {19'd0, 5'(r_count), 5'd0, r_ovf, w_full, ~w_empty};
            2'd2: HRDATA = w_empty ? 32'd0 : {1'b1, 22'd0, r_mem[r_rd_ptr]};
            default: HRDATA = r_ctrl[0] ? 32'(r_stable) : 32'd0;
        endcase
    end
endmodule
